// File: rtl/hwpe_stream_package.sv
// Shared types and helpers for the split arbiter and its round-robin picker.
package hwpe_stream_package;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // A zero length still moves one word; anything above the cap is truncated to it.
    function automatic int unsigned clamp_burst_len(input int unsigned len, input int unsigned max_len);
        if (len == 0) return 1;
        if (len > max_len) return max_len;
        return len;
    endfunction

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// Plain valid/ready stream: a word moves on every cycle where valid and ready are both high.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping around.
module hwpe_stream_rr_pick #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);
    int unsigned j;

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr_i) + i;
            if (j >= N) j = j - N;
            if (!found_o && req_i[j]) begin
                idx_o   = IW'(j);
                found_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/hwpe_stream_split_arbiter.sv
// Burst-locked round-robin arbiter: one requester owns the output stream until its
// burst length is reached or it stays idle for IDLE_TIMEOUT cycles.
module hwpe_stream_split_arbiter
    import hwpe_stream_package::*;
#(
    parameter  int unsigned NB_IN_STREAMS = 2,
    parameter  int unsigned DATA_WIDTH    = 256,
    parameter  int unsigned MAX_BURST     = 16,
    parameter  int unsigned IDLE_TIMEOUT  = 8,
    localparam int unsigned LEN_W         = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     enable_i,
    input  logic [LEN_W-1:0]         burst_len_i,
    hwpe_stream_intf_stream.sink     push_i [NB_IN_STREAMS-1:0],
    hwpe_stream_intf_stream.source   pop_o,
    output logic [NB_IN_STREAMS-1:0] grant_o,
    output logic                     busy_o,
    output logic                     burst_done_o
);
    localparam int unsigned IW  = $clog2(NB_IN_STREAMS);
    localparam int unsigned SW  = DATA_WIDTH / 8;
    localparam int unsigned IDW = 8;

    logic [NB_IN_STREAMS-1:0]                 valid_in;
    logic [NB_IN_STREAMS-1:0]                 ready_out;
    logic [NB_IN_STREAMS-1:0][DATA_WIDTH-1:0] data_in;
    logic [NB_IN_STREAMS-1:0][SW-1:0]         strb_in;

    for (genvar k = 0; k < NB_IN_STREAMS; k++) begin : gen_extract
        assign valid_in[k]    = push_i[k].valid;
        assign data_in[k]     = push_i[k].data;
        assign strb_in[k]     = push_i[k].strb;
        assign push_i[k].ready = ready_out[k];
    end

    arb_state_e               state_q, state_d;
    logic [IW-1:0]            gnt_q, gnt_d;
    logic [IW-1:0]            rr_q, rr_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d;
    logic [LEN_W-1:0]         len_q, len_d;
    logic [IDW-1:0]           idle_q, idle_d;
    logic [NB_IN_STREAMS-1:0] grant_q, grant_d;

    logic          soft_rst, locked, sel_valid, pop_valid, handshake;
    logic          last_beat, timeout, burst_end, pick_found;
    logic [IW-1:0] gnt_inc, pick_ptr, pick_idx;

    assign soft_rst  = rst_i | clear_i;
    assign locked    = (state_q == ARB_LOCK);
    assign gnt_inc   = (gnt_q == IW'(NB_IN_STREAMS - 1)) ? '0 : gnt_q + 1'b1;
    // While locked the picker is only consulted at burst end, starting after the grantee.
    assign pick_ptr  = locked ? gnt_inc : rr_q;

    hwpe_stream_rr_pick #(
        .N (NB_IN_STREAMS)
    ) u_rr_pick (
        .req_i   (valid_in),
        .ptr_i   (pick_ptr),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // A reset cycle refuses the beat so the source keeps it for after reset.
    assign sel_valid  = valid_in[gnt_q];
    assign pop_valid  = locked & ~soft_rst & sel_valid;
    assign pop_o.valid = pop_valid;
    assign pop_o.data  = data_in[gnt_q];
    assign pop_o.strb  = strb_in[gnt_q];
    assign ready_out   = (locked && !soft_rst && pop_o.ready) ? (NB_IN_STREAMS'(1) << gnt_q) : '0;

    assign handshake = pop_valid & pop_o.ready;
    assign last_beat = handshake && (cnt_q == len_q - 1'b1);
    assign timeout   = locked && !sel_valid && (idle_q == IDW'(IDLE_TIMEOUT - 1));
    assign burst_end = locked & ~soft_rst & (last_beat | timeout);

    assign grant_o      = grant_q;
    assign busy_o       = locked;
    assign burst_done_o = burst_end;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idle_d  = idle_q;
        grant_d = grant_q;
        if (locked) begin
            if (handshake) cnt_d = cnt_q + 1'b1;
            idle_d = sel_valid ? '0 : idle_q + 1'b1;
            if (burst_end) begin
                rr_d    = gnt_inc;
                state_d = ARB_IDLE;
                grant_d = '0;
                cnt_d   = '0;
                idle_d  = '0;
            end
        end
        // Issue a grant from IDLE, or back-to-back when the current burst ends.
        if ((!locked || burst_end) && enable_i && pick_found) begin
            state_d = ARB_LOCK;
            gnt_d   = pick_idx;
            cnt_d   = '0;
            idle_d  = '0;
            len_d   = LEN_W'(clamp_burst_len(32'(burst_len_i), MAX_BURST));
            grant_d = NB_IN_STREAMS'(1) << pick_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            idle_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idle_q  <= idle_d;
            grant_q <= grant_d;
        end
    end
endmodule

// File: tb/tb_hwpe_stream_split_arbiter.sv
// Directed bench for the split arbiter: two requesters, 32-bit words, MAX_BURST=16, IDLE_TIMEOUT=8.
module tb_hwpe_stream_split_arbiter;
  localparam int unsigned NB = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 5;
  localparam logic [DW-1:0] WORD_A = 32'h0000_00A0;
  localparam logic [DW-1:0] WORD_B = 32'h0000_00B1;

  logic              clk = 1'b0;
  logic              rst, clr, en;
  logic [LW-1:0]     blen;
  logic [NB-1:0]     in_valid;
  logic [NB-1:0][DW-1:0] in_data;
  logic [NB-1:0]     in_ready;
  logic              pop_ready, pop_valid;
  logic [DW-1:0]     pop_data;
  logic [NB-1:0]     grant;
  logic              busy, done;

  int n_vec = 0;
  int n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push [NB-1:0] ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop ();

  for (genvar g = 0; g < NB; g++) begin : gen_src
    assign push[g].valid = in_valid[g];
    assign push[g].data  = in_data[g];
    assign push[g].strb  = '1;
    assign in_ready[g]   = push[g].ready;
  end
  assign pop.ready = pop_ready;
  assign pop_valid = pop.valid;
  assign pop_data  = pop.data;

  hwpe_stream_split_arbiter #(
    .NB_IN_STREAMS(NB), .DATA_WIDTH(DW), .MAX_BURST(16), .IDLE_TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .enable_i(en), .burst_len_i(blen),
    .push_i(push), .pop_o(pop), .grant_o(grant), .busy_o(busy), .burst_done_o(done)
  );

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b0; in_valid = 2'b11; pop_ready = 1'b1; blen = 5'd4;
    do_reset();
    #1;
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL reset_outs: grant=%b busy=%b done=%b want 00/0/0", grant, busy, done);
    end
    n_vec++;
    if (pop_valid !== 1'b0 || in_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_handshake: pop_valid=%b in_ready=%b want 0/00", pop_valid, in_ready);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0 || grant !== 2'b00) begin
      n_err++; $display("FAIL enable_low_blocks: busy=%b grant=%b want 0/00", busy, grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    en = 1'b1; blen = 5'd4; pop_ready = 1'b1; in_valid = 2'b10; in_data[1] = 32'h100;
    #1;
    n_vec++;
    if (grant !== 2'b00 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL single_idle_cycle: grant=%b pop_valid=%b want 00/0", grant, pop_valid);
    end
    tick();
    for (int b = 0; b < 4; b++) begin
      in_data[1] = 32'h100 + 32'(b);
      #1;
      n_vec++;
      if (grant !== 2'b10 || pop_valid !== 1'b1 || pop_data !== 32'h100 + 32'(b) ||
          in_ready !== 2'b10 || done !== (b == 3)) begin
        n_err++;
        $display("FAIL single_beat%0d: grant=%b valid=%b data=%h ready=%b done=%b want 10/1/%h/10/%b",
                 b, grant, pop_valid, pop_data, in_ready, done, 32'h100 + 32'(b), (b == 3));
      end
      tick();
    end
    // stream 1 was still valid on its last beat and nobody else asked, so it is re-locked
    in_valid = 2'b00;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b10 || pop_valid !== 1'b0 || done !== (i == 7)) begin
        n_err++;
        $display("FAIL single_relock_idle%0d: grant=%b valid=%b done=%b want 10/0/%b",
                 i, grant, pop_valid, done, (i == 7));
      end
      tick();
    end
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_back_to_idle: grant=%b busy=%b want 00/0", grant, busy);
    end
  endtask

  task automatic test_fairness();
    logic [5:0] seq;
    logic       k;
    seq = 6'b001100;
    do_reset();
    en = 1'b1; blen = 5'd2; pop_ready = 1'b1; in_valid = 2'b11;
    in_data[0] = WORD_A; in_data[1] = WORD_B;
    tick();
    for (int i = 0; i < 6; i++) begin
      k = seq[i];
      #1;
      n_vec++;
      if (grant !== (2'b01 << k) || pop_valid !== 1'b1 || pop_data !== (k ? WORD_B : WORD_A)) begin
        n_err++;
        $display("FAIL fair_beat%0d: grant=%b valid=%b data=%h want %b/1/%h",
                 i, grant, pop_valid, pop_data, (2'b01 << k), (k ? WORD_B : WORD_A));
      end
      tick();
    end
  endtask

  task automatic test_enable();
    do_reset();
    en = 1'b1; blen = 5'd2; pop_ready = 1'b1; in_valid = 2'b11;
    in_data[0] = WORD_A; in_data[1] = WORD_B;
    tick();
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b01 || pop_valid !== 1'b1 || done !== (i == 1)) begin
        n_err++;
        $display("FAIL enable_hold_beat%0d: grant=%b valid=%b done=%b want 01/1/%b", i, grant, pop_valid, done, (i == 1));
      end
      tick();
    end
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      n_err++; $display("FAIL enable_release: grant=%b busy=%b want 00/0", grant, busy);
    end
    tick();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL enable_stay_idle: busy=%b want 0", busy);
    end
    en = 1'b1;
    tick();
    n_vec++;
    if (grant !== 2'b10) begin
      n_err++; $display("FAIL enable_next_rr: grant=%b want 10", grant);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0] rdy_pat;
    int         exp_w [5] = '{0, 1, 1, 2, 2};
    int         w;
    int         hs_cnt;
    rdy_pat = 5'b10101;
    w = 0; hs_cnt = 0;
    do_reset();
    en = 1'b1; blen = 5'd3; pop_ready = 1'b1; in_valid = 2'b01; in_data[0] = 32'h300;
    tick();
    for (int c = 0; c < 5; c++) begin
      pop_ready  = rdy_pat[c];
      in_data[0] = 32'h300 + 32'(w);
      #1;
      n_vec++;
      if (pop_valid !== 1'b1 || pop_data !== 32'h300 + 32'(exp_w[c]) || done !== (c == 4)) begin
        n_err++;
        $display("FAIL bp_cycle%0d: valid=%b data=%h done=%b want 1/%h/%b",
                 c, pop_valid, pop_data, done, 32'h300 + 32'(exp_w[c]), (c == 4));
      end
      if (pop_valid && pop_ready && in_ready[0]) begin
        hs_cnt++;
        w++;
      end
      tick();
    end
    n_vec++;
    if (hs_cnt != 3) begin
      n_err++; $display("FAIL bp_handshakes: got %0d want 3", hs_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    en = 1'b1; blen = 5'd16; pop_ready = 1'b1; in_valid = 2'b11;
    in_data[0] = WORD_A; in_data[1] = WORD_B;
    tick();
    #1;
    n_vec++;
    if (grant !== 2'b01 || pop_valid !== 1'b1 || pop_data !== WORD_A || done !== 1'b0) begin
      n_err++; $display("FAIL to_first_word: grant=%b valid=%b data=%h done=%b want 01/1/%h/0",
                        grant, pop_valid, pop_data, done, WORD_A);
    end
    tick();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b01 || pop_valid !== 1'b0 || done !== (i == 7)) begin
        n_err++; $display("FAIL to_idle%0d: grant=%b valid=%b done=%b want 01/0/%b", i, grant, pop_valid, done, (i == 7));
      end
      tick();
    end
    #1;
    n_vec++;
    if (grant !== 2'b10 || pop_valid !== 1'b1 || pop_data !== WORD_B) begin
      n_err++; $display("FAIL to_next_grant: grant=%b valid=%b data=%h want 10/1/%h", grant, pop_valid, pop_data, WORD_B);
    end
  endtask

  task automatic test_boundaries();
    in_valid = 2'b01; en = 1'b1; pop_ready = 1'b1; in_data[0] = WORD_A;
    clr = 1'b1;
    tick();
    clr = 1'b0; blen = 5'd0;
    #1;
    n_vec++;
    if (busy !== 1'b0 || grant !== 2'b00 || pop_valid !== 1'b0) begin
      n_err++; $display("FAIL clear_idle: busy=%b grant=%b valid=%b want 0/00/0", busy, grant, pop_valid);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b01 || pop_valid !== 1'b1 || done !== 1'b1) begin
        n_err++; $display("FAIL len0_beat%0d: grant=%b valid=%b done=%b want 01/1/1", i, grant, pop_valid, done);
      end
      tick();
    end
    clr = 1'b1;
    tick();
    clr = 1'b0; blen = 5'd20;
    tick();
    for (int i = 0; i < 17; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b01 || pop_valid !== 1'b1 || done !== (i == 15)) begin
        n_err++; $display("FAIL len20_beat%0d: grant=%b valid=%b done=%b want 01/1/%b", i, grant, pop_valid, done, (i == 15));
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    en = 1'b1; blen = 5'd1; pop_ready = 1'b1; in_valid = 2'b01;
    in_data[0] = WORD_A; in_data[1] = WORD_B;
    tick();
    // a one-word burst on stream 0 moves the pointer to stream 1
    blen = 5'd5; in_valid = 2'b11;
    #1;
    n_vec++;
    if (grant !== 2'b01 || done !== 1'b1) begin
      n_err++; $display("FAIL rm_first_burst: grant=%b done=%b want 01/1", grant, done);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      n_vec++;
      if (grant !== 2'b10 || pop_valid !== 1'b1 || pop_data !== WORD_B || done !== 1'b0) begin
        n_err++; $display("FAIL rm_beat%0d: grant=%b valid=%b data=%h done=%b want 10/1/%h/0",
                          i, grant, pop_valid, pop_data, done, WORD_B);
      end
      tick();
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 2'b00 || pop_valid !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL rm_inflight_refused: ready=%b valid=%b done=%b want 00/0/0", in_ready, pop_valid, done);
    end
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (grant !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || pop_valid !== 1'b0 || in_ready !== 2'b00) begin
      n_err++; $display("FAIL rm_after_reset: grant=%b busy=%b done=%b valid=%b ready=%b want 00/0/0/0/00",
                        grant, busy, done, pop_valid, in_ready);
    end
    tick();
    n_vec++;
    if (grant !== 2'b01) begin
      n_err++; $display("FAIL rm_first_grant: grant=%b want 01", grant);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; en = 1'b0; blen = '0;
    in_valid = '0; in_data = '0; pop_ready = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_enable();
    test_backpressure();
    test_timeout();
    test_boundaries();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hwpe_stream_split_arbiter.md
HWPE_STREAM_SPLIT_ARBITER -- requirements
Module: hwpe_stream_split_arbiter

Interface
REQ-001 SHALL have parameter NB_IN_STREAMS, default 2, the number of requester wide streams (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 256, the width of every input stream and of the output stream.
REQ-003 SHALL have parameter MAX_BURST, default 16, the maximum words per locked burst.
REQ-004 SHALL have parameter IDLE_TIMEOUT, default 8, the number of consecutive idle cycles that releases a lock (1..255).
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_i, input, 1 bit, the synchronous active-high reset.
REQ-007 SHALL have port clear_i, input, 1 bit, a synchronous soft clear with the same effect as rst_i.
REQ-008 SHALL have port enable_i, input, 1 bit; when low, no new grant is issued and a held grant is kept.
REQ-009 SHALL have port burst_len_i, input, $clog2(MAX_BURST+1) bits, the words per burst; it is sampled at grant.
REQ-010 SHALL have port push_i, an array of NB_IN_STREAMS hwpe_stream_intf_stream.sink interfaces of DATA_WIDTH, the requesters.
REQ-011 SHALL have port pop_o, a hwpe_stream_intf_stream.source interface of DATA_WIDTH, which feeds the downstream strided splitter.
REQ-012 SHALL have port grant_o, output, NB_IN_STREAMS bits, the one-hot current grant (0 when idle).
REQ-013 SHALL have port busy_o, output, 1 bit, high while in state LOCK.
REQ-014 SHALL have port burst_done_o, output, 1 bit, a one-cycle pulse when a burst ends for any reason.

Function
REQ-015 SHALL implement FSM states IDLE and LOCK, with a registered grant index gnt_q and a round-robin pointer rr_q.
REQ-016 SHALL, in IDLE with enable_i high and at least one push_i[k].valid high, select the first valid k in order rr_q, rr_q+1, ... (mod NB_IN_STREAMS) and enter LOCK with gnt_q=k on the next edge.
REQ-017 SHALL make latency exactly 1 cycle from a request seen in IDLE to the first possible pop_o handshake.
REQ-018 SHALL, in LOCK, combinationally pass the granted stream through: pop_o.data/strb/valid = push_i[gnt_q] and push_i[gnt_q].ready = pop_o.ready.
REQ-019 SHALL hold push_i[k].ready low for every non-granted k, and hold all push_i ready and pop_o.valid low in IDLE.
REQ-020 SHALL count pop_o handshakes (valid && ready) in a beat counter that is cleared at grant.
REQ-021 SHALL treat a sampled burst_len_i of 0 as 1, and a value above MAX_BURST as MAX_BURST.
REQ-022 SHALL end the burst on the handshake cycle of the last beat.
REQ-023 SHALL end the burst when the granted stream has valid low for IDLE_TIMEOUT consecutive cycles; any valid-high cycle resets the idle counter.
REQ-024 SHALL, at burst end, set rr_q = gnt_q+1 (mod NB_IN_STREAMS).
REQ-025 SHALL, at burst end with enable_i high, arbitrate in the same cycle from the new rr_q over the current valids and enter LOCK with the winner (back-to-back, no bubble), else go to IDLE.
REQ-026 SHALL allow the previous grantee to win back-to-back only when no other stream is valid.
REQ-027 SHALL keep pop_o payload stable while pop_o.valid is high and ready is low, since it is a pass-through of a compliant source.
REQ-028 SHALL keep any lowering of enable_i during LOCK from affecting the current burst; it only blocks the next grant.
REQ-029 SHALL, on rst_i or clear_i mid-burst, drop the grant in the same edge, so that the beat in flight is not counted and the source must re-present it.

Reset
REQ-030 SHALL, on rst_i or clear_i, set state=IDLE, gnt_q=0, rr_q=0, beat and idle counters to 0, and grant_o=0, busy_o=0, burst_done_o=0, pop_o.valid=0, and all push_i ready=0.
REQ-031 SHALL give clear_i no priority over rst_i; both are equivalent and synchronous.

Structure
REQ-032 SHALL place the state enum (ARB_IDLE, ARB_LOCK) in hwpe_stream_package.
REQ-033 SHALL instantiate one sub-module, hwpe_stream_rr_pick, a combinational round-robin first-one picker (inputs: request vector and pointer; outputs: index and found flag), used for both IDLE and back-to-back arbitration.
REQ-034 SHALL avoid non-constant indexing into interface arrays by extracting valid, data, strb and ready into packed arrays in generate loops.

Verification
REQ-035 SHALL cover single requester: push_i[1] valid for 4 words, burst_len=4, ready=1 -> grant_o=2'b10 one cycle later, 4 handshakes, burst_done_o pulses on the 4th, then IDLE.
REQ-036 SHALL cover fairness: both streams always valid, burst_len=2 -> grant sequence 0,0,1,1,0,0 with no bubble cycle between bursts.
REQ-037 SHALL cover backpressure: pop_o.ready toggling 1010 over a burst_len=3 burst -> exactly 3 handshakes, payload stable while stalled, no data loss.
REQ-038 SHALL cover timeout: granted stream goes invalid after 1 word, IDLE_TIMEOUT=8, other stream valid -> release after exactly 8 idle cycles and grant the other stream next.
REQ-039 SHALL cover boundaries: burst_len=0 -> 1-word bursts; burst_len=20 with MAX_BURST=16 -> 16-word bursts.
REQ-040 SHALL cover reset mid-burst: rst_i pulsed after beat 2 of 5 -> next cycle all outputs at reset values, rr_q=0, and the first grant after reset goes to stream 0.
